// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit (multiplier/divider).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arith_pkg;

    localparam int DEF_WIDTH = 64;

    // Iteration counter width for a given operand width.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

    localparam int CNT_W = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/subtractor_df.sv
// Trial subtractor for the restoring divider: diff = a - {0,b}, MSB is the borrow.
// Latency: combinational.
// Backpressure: none.
module subtractor_df #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   diff
);

    assign diff = a - {1'b0, b};

endmodule

// File: rtl/seq_divider_restoring.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock.
// Latency: done WIDTH+1 cycles after an accepted start (1 cycle for divide-by-zero).
// Backpressure: start is ignored while busy; a start in the FIN cycle is taken back-to-back.
module seq_divider_restoring
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    cnt;
    logic             dz_reg;

    logic             accept;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   trial;

    assign accept  = start && ((state == IDLE) || (state == FIN));
    assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign q_shift = {q_reg[WIDTH-2:0], 1'b0};

    subtractor_df #(.WIDTH(WIDTH)) u_sub (
        .a    (r_shift),
        .b    (d_reg),
        .diff (trial)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; a zero divisor skips the iterations and goes straight to FIN.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = (divisor == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_n = FIN;
                end
            end
            FIN: begin
                if (start) begin
                    state_n = (divisor == '0) ? FIN : RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Working registers: operand load on accept, one shift/trial-subtract per RUN cycle.
    // A zero divisor preloads the fixed result so FIN can publish it like any other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg  <= '0;
            q_reg  <= '0;
            d_reg  <= '0;
            cnt    <= '0;
            dz_reg <= 1'b0;
        end else if (accept) begin
            d_reg <= divisor;
            cnt   <= '0;
            if (divisor == '0) begin
                r_reg  <= {1'b0, dividend};
                q_reg  <= '1;
                dz_reg <= 1'b1;
            end else begin
                r_reg  <= '0;
                q_reg  <= dividend;
                dz_reg <= 1'b0;
            end
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            if (!trial[WIDTH]) begin
                r_reg <= trial;
                q_reg <= q_shift | {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_reg <= r_shift;
                q_reg <= q_shift;
            end
        end
    end

    // Output registers: results published from FIN, held until the next op reaches FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done <= (state == FIN);
            busy <= (state_n == RUN) || accept;
            if (state == FIN) begin
                quotient    <= q_reg;
                remainder   <= r_reg[WIDTH-1:0];
                div_by_zero <= dz_reg;
            end
        end
    end

endmodule
